wishbone_arbiter_2m: RTL
========================

WISHBONE_ARBITER_2M -- requirements
Module: wishbone_arbiter_2m

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 256, stall limit in clocks; used only with WB_ARB_TIMEOUT_EN; legal range 2..65535.
REQ-002 Ports, one per line (name direction width meaning):
 clk  in  1  single clock, all logic on rising edge
 rst  in  1  synchronous, active-high reset
 m0_we_i, m0_stb_i, m0_cyc_i  in  1 each  master 0 write-enable, strobe, cycle
 m0_adr_i, m0_dat_i  in  32 each  master 0 address, write data
 m0_dat_o  out  32  master 0 read data
 m0_ack_o, m0_int_o  out  1 each  master 0 acknowledge, interrupt
 m1_*  same set as m0_*  master 1
 s_we_o, s_stb_o, s_cyc_o  out  1 each  to shared slave
 s_adr_o, s_dat_o  out  32 each  to shared slave
 s_dat_i  in  32  slave read data
 s_ack_i, s_int_i  in  1 each  slave acknowledge, interrupt
 timeout_o  out  1  one-cycle stall-timeout pulse
REQ-003 One clock; reset is synchronous and active-high; ports named clk and rst.

Function
REQ-004 FSM states: IDLE, GNT0, GNT1; a 1-bit register last holds the most recently granted master.
REQ-005 IDLE: m0_cyc_i only -> GNT0; m1_cyc_i only -> GNT1; both -> grant the master != last; neither -> stay IDLE.
REQ-006 Grant is registered: cyc asserted at edge N produces slave-side cyc/stb at earliest in cycle N+1.
REQ-007 On entering GNTx, last SHALL be set to x.
REQ-008 GNTx: s_we_o, s_stb_o, s_cyc_o, s_adr_o, s_dat_o SHALL be combinational copies of master x inputs.
REQ-009 GNTx: mx_dat_o = s_dat_i, mx_ack_o = s_ack_i; other master: dat_o = 0, ack_o = 0.
REQ-010 IDLE: all slave-side outputs 0; both masters' ack_o = 0, dat_o = 0.
REQ-011 GNTx held while mx_cyc_i = 1, across any number of stb/ack beats (block/RMW transfers not split).
REQ-012 GNTx with mx_cyc_i = 0 -> IDLE next cycle; slave cyc follows master cyc combinationally in that cycle (0).
REQ-013 Exactly one dead IDLE cycle between consecutive grants; back-to-back requesters alternate (round-robin).
REQ-014 A master's own cyc re-assertion in the same IDLE cycle as another's request loses to the other (fairness via last).
REQ-015 m0_int_o = m1_int_o = s_int_i, combinational, in every state.
REQ-016 Non-granted master's stb/we/adr/dat SHALL have no effect on any output.

Reset
REQ-017 rst = 1 at a clock edge: state -> IDLE, last -> 1 (master 0 wins first tie), stall counter -> 0, timeout_o -> 0.
REQ-018 Reset mid-grant: slave cyc/stb SHALL be 0 in the cycle after the reset edge; no ack forwarded.
REQ-019 All outputs SHALL equal their IDLE values (REQ-010) while rst is asserted from the first edge.

Configuration
REQ-020 Macro WB_ARB_TIMEOUT_EN defined: 16-bit stall counter increments each GNTx cycle with mx_stb_i = 1 and s_ack_i = 0; clears on s_ack_i or state exit.
REQ-021 With WB_ARB_TIMEOUT_EN, counter reaching TIMEOUT_CYCLES-1 while stalled: next cycle mx_ack_o = 1 with mx_dat_o = 32'hFFFFFFFF, slave cyc/stb = 0, timeout_o = 1 (one cycle), then -> IDLE.
REQ-022 Without WB_ARB_TIMEOUT_EN: no counter, timeout_o tied 0, a stalled grant is held indefinitely.

Verification
REQ-023 After reset, m0 and m1 assert cyc/stb same cycle -> m0 granted (s_adr_o = m0_adr_i next cycle); after m0 drops cyc, one IDLE cycle, then m1 granted.
REQ-024 m0 read adr 32'h0000_0010, slave returns s_dat_i = 32'hCAFE_F00D with ack -> m0_dat_o = 32'hCAFE_F00D, m0_ack_o = 1, m1_ack_o = 0, m1_dat_o = 0.
REQ-025 m1 holds cyc for 4 write beats while m0 requests throughout -> all 4 beats reach slave from m1; m0 granted only after m1 cyc drops.
REQ-026 rst pulsed during GNT1 -> s_cyc_o = 0 next cycle; with both requesting after reset, m0 granted.
REQ-027 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave never acks -> 8 stalled cycles, then m0_ack_o = 1, m0_dat_o = 32'hFFFFFFFF, timeout_o = 1 for one cycle, state IDLE; macro undefined -> grant held, timeout_o = 0.
REQ-028 s_int_i toggled in IDLE, GNT0, GNT1 -> m0_int_o and m1_int_o follow it same cycle in all states.

Source files
------------

// File: rtl/wishbone_arbiter_2m.sv
// Two-master Wishbone arbiter in front of a single shared slave.
// Grants are registered and round-robin: on a simultaneous request the master
// that was not granted last wins, and a grant is held for as long as the
// granted master keeps cyc high, so block and read-modify-write transfers are
// never split. Every pair of grants is separated by one IDLE cycle.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to enable a stall watchdog. When
// the granted master strobes for TIMEOUT_CYCLES clocks without a slave ack,
// the arbiter answers the master itself with ack and all-ones data, pulses
// timeout_o for one cycle and releases the bus.
//
// state | meaning
// IDLE  | no grant; slave side and master acks held at 0
// GNT0  | master 0 owns the slave; its signals pass straight through
// GNT1  | master 1 owns the slave; its signals pass straight through

module wishbone_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_int_o,

    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_int_o,

    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_int_i,

    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        last;
    logic        tout_q;
    logic        granted;
    logic        gsel;

    logic        sel_we;
    logic        sel_stb;
    logic        sel_cyc;
    logic [31:0] sel_adr;
    logic [31:0] sel_dat;

    assign granted = (state == GNT0) || (state == GNT1);
    assign gsel    = (state == GNT1);

    // Pick out the inputs of whichever master the current state names.
    always_comb begin
        sel_we  = gsel ? m1_we_i  : m0_we_i;
        sel_stb = gsel ? m1_stb_i : m0_stb_i;
        sel_cyc = gsel ? m1_cyc_i : m0_cyc_i;
        sel_adr = gsel ? m1_adr_i : m0_adr_i;
        sel_dat = gsel ? m1_dat_i : m0_dat_i;
    end

    // Grant state machine; last remembers the most recent winner for round-robin.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last)) begin
                        state <= GNT0;
                        last  <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state <= GNT1;
                        last  <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (tout_q || !sel_cyc) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] stall_cnt;

    // Count stalled strobe cycles of the current grant; flag the terminal one.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            tout_q    <= 1'b0;
        end else if (!granted || tout_q || !sel_cyc) begin
            stall_cnt <= 16'd0;
            tout_q    <= 1'b0;
        end else if (s_ack_i) begin
            stall_cnt <= 16'd0;
        end else if (sel_stb) begin
            if (stall_cnt == TOUT_LAST) begin
                tout_q <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_cfg;

    // Without the watchdog a stalled grant simply waits for the slave.
    assign tout_q     = 1'b0;
    assign unused_cfg = ^TOUT_LAST;
`endif

    // Route the bus: pass-through for the owner, zeros elsewhere,
    // and a synthetic error-style ack in the timeout cycle.
    always_comb begin
        s_we_o    = 1'b0;
        s_stb_o   = 1'b0;
        s_cyc_o   = 1'b0;
        s_adr_o   = 32'd0;
        s_dat_o   = 32'd0;
        m0_dat_o  = 32'd0;
        m0_ack_o  = 1'b0;
        m1_dat_o  = 32'd0;
        m1_ack_o  = 1'b0;
        m0_int_o  = s_int_i;
        m1_int_o  = s_int_i;
        timeout_o = tout_q;
        if (granted) begin
            if (tout_q) begin
                if (gsel) begin
                    m1_ack_o = 1'b1;
                    m1_dat_o = 32'hFFFF_FFFF;
                end else begin
                    m0_ack_o = 1'b1;
                    m0_dat_o = 32'hFFFF_FFFF;
                end
            end else begin
                s_we_o  = sel_we;
                s_stb_o = sel_stb;
                s_cyc_o = sel_cyc;
                s_adr_o = sel_adr;
                s_dat_o = sel_dat;
                if (gsel) begin
                    m1_dat_o = s_dat_i;
                    m1_ack_o = s_ack_i;
                end else begin
                    m0_dat_o = s_dat_i;
                    m0_ack_o = s_ack_i;
                end
            end
        end
    end

endmodule
